alu_cc_pipe: RTL and testbench
==============================

Name: alu_cc_pipe

Overview:
- Registered, handshaked successor to the combinational Y86 execute ALU.
- Performs ADD/SUB/AND/XOR on parametrised-width operands and holds a one-entry result register with valid/ready flow control.
- Owns the condition-code register (ZF, SF, OF) and evaluates Y86 branch/cmov conditions against it.
- Sits in the Execute stage, between operand select and the memory/writeback path.

Parameters:
WIDTH, 64, operand/result width in bits; legal range 8..64.
CC_RESET, 3'b100, reset value of {ZF,SF,OF} (ZF=1, matching Y86 architectural reset).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation offered.
in_ready  output  1  block can accept an operation this cycle.
in_a  input  WIDTH  operand A (valA, signed two's complement).
in_b  input  WIDTH  operand B (valB, signed two's complement).
in_fn  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
in_set_cc  input  1  update CC with this operation's flags.
out_valid  output  1  result register holds a result.
out_ready  input  1  consumer takes result this cycle.
out_result  output  WIDTH  registered result.
out_ovf  output  1  registered overflow flag of the held result.
cc  output  3  {ZF,SF,OF} architectural condition codes.
cnd_fn  input  3  Y86 condition: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 always.
cnd  output  1  combinational condition result from current cc.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - out_valid=0, out_result=0, out_ovf=0, cc=CC_RESET.
  - Any held or in-flight result is discarded.
  - in_ready reads 1 as soon as rst_n deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; full throughput, no bubble).
  - Accept = in_valid && in_ready.
  - Drain = out_valid && out_ready.
  - On accept: the result register loads on the next rising edge, and out_valid=1 from that edge. Latency is exactly 1 cycle.
  - On drain without accept: out_valid=0 next edge; out_result and out_ovf hold their stale value.
  - Simultaneous accept and drain: the register reloads with the new result and out_valid stays 1.
  - No accept and no drain: all outputs hold. in_* are don't-care when in_valid=0.
- Arithmetic (Y86 ordering, result = B op A), modulo 2^WIDTH:
  - ADD: b + a. Overflow = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
  - SUB: b - a. Overflow = (a[W-1]!=b[W-1]) && (r[W-1]!=b[W-1]).
  - AND, XOR: bitwise; overflow = 0.
  - Carry-out is discarded. The most-negative value wraps without error (e.g. 0 - MIN = MIN, OF=1).
- Condition codes:
  - Updated on the accept edge only when in_set_cc=1: ZF = (r==0), SF = r[W-1], OF = overflow.
  - Accepts with in_set_cc=0, and cycles without accept, leave cc unchanged.
  - cc is not gated by out_ready; the update follows acceptance, not drain.
- Condition evaluation (combinational from cc):
  - le = (SF^OF)|ZF; l = SF^OF; e = ZF; ne = !ZF; ge = !(SF^OF); g = !(SF^OF)&!ZF.
  - Codes 0 and 7 give 1.
  - cnd reflects the new cc in the cycle after a set_cc accept.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately, cc=3'b100; after release, cnd_fn=3 -> cnd=1.
- SUB with set_cc, WIDTH=64, in_a=4, in_b=11, in_fn=01 -> next cycle out_result=7, out_ovf=0, cc=000. Then a=11, b=4 -> out_result=-7, cc=010, cnd(l)=1.
- Overflow: in_a=1, in_b=64'h7FFF_FFFF_FFFF_FFFF, ADD, set_cc -> out_result=64'h8000_0000_0000_0000, out_ovf=1, cc=011, cnd(l)=0, cnd(ge)=1.
- Logic ops: a=64'hB, b=64'h4, AND -> 0 and ZF=1; XOR -> 64'hF, OF=0.
- No CC update: an op with set_cc=0 leaves cc unchanged.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, result holds for 3 cycles with no cc change. Then out_ready=1 with in_valid=1 -> new result loaded back-to-back with no bubble.
- Streaming: 8 consecutive ops with in_valid=out_ready=1 -> one result per cycle in order, each 1 cycle after its accept.
- WIDTH=8 build: a=8'h01, b=8'h7F, ADD -> 8'h80, OF=1. Then a=8'h80, b=8'h00, SUB -> 8'h80, OF=1.

Source files
------------

// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: registered Y86 execute ALU with a one-entry valid/ready result
// register, the architectural condition-code register {ZF,SF,OF}, and the
// combinational branch/cmov condition evaluator that reads it.
module alu_cc_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_fn,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic [2:0]       cc,
  input  logic [2:0]       cnd_fn,
  output logic             cnd
);

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_AND = 2'b10,
    FN_XOR = 2'b11
  } alu_fn_e;

  typedef enum logic [2:0] {
    C_ALWAYS = 3'd0,
    C_LE     = 3'd1,
    C_L      = 3'd2,
    C_E      = 3'd3,
    C_NE     = 3'd4,
    C_GE     = 3'd5,
    C_G      = 3'd6,
    C_ALWAYS7 = 3'd7
  } cond_e;

  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             accept;
  logic             drain;
  logic             zf, sf, of;

  // A new operation can enter whenever the register is empty or being emptied.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Y86 ordering: result = B op A, modulo 2^WIDTH, carry-out dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    res = '0;
    ovf = 1'b0;
    case (alu_fn_e'(in_fn))
      FN_ADD: begin
        res = in_b + in_a;
        ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
      end
      FN_SUB: begin
        res = in_b - in_a;
        ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_b[WIDTH-1]);
      end
      FN_AND: res = in_b & in_a;
      FN_XOR: res = in_b ^ in_a;
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  // Result register: load on accept, clear valid on drain-only, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= res;
        out_ovf    <= ovf;
      end else if (drain) begin
        out_valid  <= 1'b0;
      end
    end
  end

  // Condition codes follow acceptance (not drain), and only when requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (accept && in_set_cc) begin
      cc <= {(res == '0), res[WIDTH-1], ovf};
    end
  end

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  // Branch/cmov condition evaluated straight from the current cc.
  always_comb begin
    cnd = 1'b1;
    case (cond_e'(cnd_fn))
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = !zf;
      C_GE:    cnd = !(sf ^ of);
      C_G:     cnd = !(sf ^ of) && !zf;
      default: cnd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Directed testbench for alu_cc_pipe: a 64-bit instance carries most vectors,
// an 8-bit instance covers the narrow-width overflow corners.
module tb_alu_cc_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, in_set_cc, out_valid, out_ready, out_ovf, cnd;
  logic [63:0] in_a, in_b, out_result;
  logic [1:0]  in_fn;
  logic [2:0]  cc, cnd_fn;

  logic        n_in_valid, n_in_ready, n_in_set_cc, n_out_valid, n_out_ready, n_out_ovf, n_cnd;
  logic [7:0]  n_in_a, n_in_b, n_out_result;
  logic [1:0]  n_in_fn;
  logic [2:0]  n_cc, n_cnd_fn;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, XOR_ = 2'b11;

  alu_cc_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_fn(in_fn), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf),
    .cc(cc), .cnd_fn(cnd_fn), .cnd(cnd)
  );

  alu_cc_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_fn(n_in_fn), .in_set_cc(n_in_set_cc),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_result(n_out_result), .out_ovf(n_out_ovf),
    .cc(n_cc), .cnd_fn(n_cnd_fn), .cnd(n_cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offer one op to the 64-bit instance at the falling edge; return 1ns after
  // the accepting rising edge with in_valid dropped.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] fn, input logic set_cc);
    @(negedge clk);
    in_a = a; in_b = b; in_fn = fn; in_set_cc = set_cc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] fn, input logic set_cc);
    @(negedge clk);
    n_in_a = a; n_in_b = b; n_in_fn = fn; n_in_set_cc = set_cc; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_fn = 0; in_set_cc = 0; out_ready = 1; cnd_fn = 0;
    n_in_valid = 0; n_in_a = 0; n_in_b = 0; n_in_fn = 0; n_in_set_cc = 0; n_out_ready = 1; n_cnd_fn = 0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_cc", cc, 3'b100);
    check("rst_result", out_result, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_in_ready", in_ready, 1);
    cnd_fn = 3; #1;
    check("rst_cnd_e", cnd, 1);

    // SUB 11-4 = 7
    do_op(64'd4, 64'd11, SUB, 1);
    check("sub_valid", out_valid, 1);
    check("sub_result", out_result, 64'd7);
    check("sub_ovf", out_ovf, 0);
    check("sub_cc", cc, 3'b000);

    // SUB 4-11 = -7
    do_op(64'd11, 64'd4, SUB, 1);
    check("subn_result", out_result, 64'hFFFF_FFFF_FFFF_FFF9);
    check("subn_cc", cc, 3'b010);
    cnd_fn = 2; #1;
    check("subn_cnd_l", cnd, 1);

    // Signed overflow on ADD
    do_op(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, ADD, 1);
    check("ovf_result", out_result, 64'h8000_0000_0000_0000);
    check("ovf_flag", out_ovf, 1);
    check("ovf_cc", cc, 3'b011);
    cnd_fn = 2; #1;
    check("ovf_cnd_l", cnd, 0);
    cnd_fn = 5; #1;
    check("ovf_cnd_ge", cnd, 1);
    cnd_fn = 1; #1;
    check("ovf_cnd_le", cnd, 0);

    // 0 - MIN wraps to MIN with OF
    do_op(64'h8000_0000_0000_0000, 64'd0, SUB, 1);
    check("min_result", out_result, 64'h8000_0000_0000_0000);
    check("min_ovf", out_ovf, 1);

    // Logic ops
    do_op(64'hB, 64'h4, AND_, 1);
    check("and_result", out_result, 64'h0);
    check("and_cc", cc, 3'b100);
    cnd_fn = 4; #1;
    check("and_cnd_ne", cnd, 0);
    do_op(64'hB, 64'h4, XOR_, 1);
    check("xor_result", out_result, 64'hF);
    check("xor_ovf", out_ovf, 0);
    check("xor_cc", cc, 3'b000);
    cnd_fn = 6; #1;
    check("xor_cnd_g", cnd, 1);

    // set_cc=0 leaves cc alone even for a zero result
    do_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, ADD, 0);
    check("nocc_result", out_result, 64'd0);
    check("nocc_cc", cc, 3'b000);

    // Drain without accept: valid drops, data holds
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);
    check("drain_hold", out_result, 64'd0);

    // Backpressure
    @(negedge clk); out_ready = 1'b0;
    do_op(64'd2, 64'd3, ADD, 0);
    check("bp_first", out_result, 64'd5);
    @(negedge clk);
    in_a = 64'd10; in_b = 64'hFFFF_FFFF_FFFF_FFEC; in_fn = ADD; in_set_cc = 1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_result%0d", k), out_result, 64'd5);
      check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      check($sformatf("bp_in_ready%0d", k), in_ready, 0);
      check($sformatf("bp_cc%0d", k), cc, 3'b000);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_result", out_result, 64'hFFFF_FFFF_FFFF_FFF6);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_cc", cc, 3'b010);

    // Streaming: one result per cycle, each one cycle after its accept
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_a = 64'(i); in_b = 64'(100 * i); in_fn = ADD; in_set_cc = 0; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stream_result%0d", i), out_result, 64'(101 * i));
      check($sformatf("stream_valid%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_end_valid", out_valid, 0);

    // 8-bit corners
    do_op8(8'h01, 8'h7F, ADD, 1);
    check("w8_add_result", n_out_result, 8'h80);
    check("w8_add_ovf", n_out_ovf, 1);
    do_op8(8'h80, 8'h00, SUB, 1);
    check("w8_sub_result", n_out_result, 8'h80);
    check("w8_sub_ovf", n_out_ovf, 1);
    check("w8_sub_cc", n_cc, 3'b011);

    // Asynchronous reset mid-stream with a held result
    @(negedge clk); out_ready = 1'b0;
    do_op(64'd7, 64'd9, ADD, 1);
    check("mid_valid_before", out_valid, 1);
    #2 rst_n = 1'b0; #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cc", cc, 3'b100);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_ovf", out_ovf, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; cnd_fn = 3; #1;
    check("mid_rel_ready", in_ready, 1);
    check("mid_rel_cnd_e", cnd, 1);
    cnd_fn = 7; #1;
    check("mid_rel_cnd_7", cnd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
